// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: NUM_IN:1 registered select stage with a one-entry skid
// buffer so in_ready comes straight from a flop. Flush squashes both entries;
// an out-of-range select yields all-zero data.
module mux_pipe_skid #(
  parameter  int WIDTH  = 64,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [WIDTH-1:0]   mux_val;
  logic               accept, consume;

  // Input select; unmatched (out-of-range) selects leave the zero default.
  always_comb begin
    mux_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_val = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign data_out  = main_q;
  assign in_ready  = in_ready_q;

  // Next state and data moves; flush overrides any accept/consume this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = mux_val;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_d = mux_val;
        end else if (accept) begin
          skid_d  = mux_val;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != FULL);
  end

  // State, data and ready registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_mux_pipe_skid.sv
// tb_mux_pipe_skid: directed and random checks of mux_pipe_skid against a
// two-deep queue model of the select stage.
module tb_mux_pipe_skid;

  localparam int W = 64;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] data_in;
  logic [1:0]     sel;
  logic           in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0]   data_out;

  // Small second instance for the out-of-range select case.
  logic [23:0]    data_in3;
  logic [1:0]     sel3;
  logic           in_valid3, in_ready3, flush3, out_valid3, out_ready3;
  logic [7:0]     data_out3;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  mux_pipe_skid #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_skid #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .data_out(data_out3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input int s);
    if (s < N) return d[s*W +: W];
    return '0;
  endfunction

  // Outputs against the queue model: ready while fewer than two held.
  task automatic chk_model(input string tag);
    chk({tag, ".in_ready"},  W'(in_ready),  W'(q.size() < 2));
    chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".data_out"}, data_out, q[0]);
  endtask

  // Drive one cycle (called at negedge), advance the model, check next negedge.
  task automatic cyc(input logic iv, input int s, input logic [N*W-1:0] d,
                     input logic ordy, input logic fl, input string tag);
    logic acc, con;
    in_valid = iv; sel = 2'(s); data_in = d; out_ready = ordy; flush = fl;
    acc = iv && (q.size() < 2);
    con = ordy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(pick(d, s));
    end
    @(negedge clk);
    chk_model(tag);
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N*W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  logic [N*W-1:0] stream_d;
  logic [N*W-1:0] d7, d9, d55;

  initial begin
    reset_n = 1'b0; in_valid = 0; sel = 0; data_in = '0; out_ready = 0; flush = 0;
    in_valid3 = 0; sel3 = 0; data_in3 = '0; out_ready3 = 0; flush3 = 0;
    #12;
    chk("reset.out_valid", W'(out_valid), 0);
    chk("reset.data_out",  data_out, 0);
    chk("reset.in_ready",  W'(in_ready), 1);
    @(negedge clk); reset_n = 1'b1;

    // Streaming select: inputs {10,100,0,5}, sel 0..3 back to back.
    stream_d = {64'd5, 64'd0, 64'd100, 64'd10};
    cyc(1, 0, stream_d, 1, 0, "stream0"); chk("stream0.val", data_out, 10);
    cyc(1, 1, stream_d, 1, 0, "stream1"); chk("stream1.val", data_out, 100);
    cyc(1, 2, stream_d, 1, 0, "stream2"); chk("stream2.val", data_out, 0);
    chk("stream2.ov", W'(out_valid), 1);
    cyc(1, 3, stream_d, 1, 0, "stream3"); chk("stream3.val", data_out, 5);
    chk("stream3.rdy", W'(in_ready), 1);
    cyc(0, 0, stream_d, 1, 0, "stream_end");

    // Backpressure: two accepts with out_ready low fill the block.
    d7 = '0; d7[W-1:0] = 64'd7;
    d9 = '0; d9[W-1:0] = 64'd9;
    cyc(1, 0, d7, 0, 0, "bp0");
    cyc(1, 0, d9, 0, 0, "bp1");
    chk("bp.full_ready", W'(in_ready), 0);
    chk("bp.head7", data_out, 7);
    cyc(1, 0, d9, 0, 0, "bp_stall");  // offered but blocked
    cyc(0, 0, d9, 1, 0, "bp2"); chk("bp.then9", data_out, 9);
    cyc(0, 0, d9, 1, 0, "bp3"); chk("bp.drained", W'(out_valid), 0);

    // Flush while FULL with a new offer: everything squashed.
    d55 = '0; d55[W-1:0] = 64'h55;
    cyc(1, 0, d7, 0, 0, "fl0");
    cyc(1, 0, d9, 0, 0, "fl1");
    cyc(1, 0, d55, 0, 1, "fl2");
    chk("flush.ov", W'(out_valid), 0);
    chk("flush.rdy", W'(in_ready), 1);
    cyc(0, 0, d55, 1, 0, "fl3"); chk("flush.gone", W'(out_valid), 0);

    // Out-of-range select on the 3-input instance, then an in-range one.
    data_in3 = 24'h33_22_11; sel3 = 2'd3; in_valid3 = 1;
    @(negedge clk); in_valid3 = 0;
    chk("oor.ov", W'(out_valid3), 1);
    chk("oor.zero", W'(data_out3), 0);
    out_ready3 = 1; sel3 = 2'd2; in_valid3 = 1;
    @(negedge clk); in_valid3 = 0; out_ready3 = 0;
    chk("sel2.val", W'(data_out3), 64'h33);

    // Async reset mid-cycle while FULL.
    cyc(1, 0, d7, 0, 0, "ar0");
    cyc(1, 0, d9, 0, 0, "ar1");
    in_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("areset.ov",  W'(out_valid), 0);
    chk("areset.do",  data_out, 0);
    chk("areset.rdy", W'(in_ready), 1);
    q.delete();
    @(negedge clk); reset_n = 1'b1;

    // Random stress with upstream holding an offer until it is taken.
    begin
      logic iv = 0, fl;
      int s = 0;
      logic [N*W-1:0] d = '0;
      for (int c = 0; c < 10000; c++) begin
        fl = ($urandom_range(0, 39) == 0);
        if (!(iv && !in_ready)) begin
          iv = ($urandom_range(0, 3) != 0);
          s  = $urandom_range(0, N-1);
          d  = rnd_data();
        end
        cyc(iv, s, d, ($urandom_range(0, 2) != 0), fl, "rand");
        if (fl) iv = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
